// File: rtl/qupls4_imul_pipe.sv
// qupls4_imul_pipe: fully pipelined integer multiplier (low/high half, tagged, flushable)
// Ports: clk/rst (sync, active-high); issue/op/a/b/tag accept one op per cycle;
//        flush kills everything in flight; o/o_tag/ovf are valid while mul_done pulses,
//        and hold their values otherwise.
module qupls4_imul_pipe #(
    parameter int WID    = 64,
    parameter int STAGES = 3,
    parameter int TAGW   = 8,
    parameter int LANE   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic [2:0]      op,
    input  logic [WID-1:0]  a,
    input  logic [WID-1:0]  b,
    input  logic [TAGW-1:0] tag,
    input  logic            flush,
    output logic [WID-1:0]  o,
    output logic [TAGW-1:0] o_tag,
    output logic            ovf,
    output logic            mul_done
);
    localparam int PW = 2 * WID;

    if (WID % 16 != 0 || WID < 16 || WID > 128 || STAGES < 2 || STAGES > 8 || LANE < 0) begin : g_bad_param
        $error("qupls4_imul_pipe: unsupported parameter set");
    end

    logic [STAGES-1:0] v_q, v_d;
    logic [PW-1:0]     p_q   [STAGES];
    logic [2:0]        op_q  [STAGES];
    logic [TAGW-1:0]   tag_q [STAGES];
    logic [PW-1:0]     xa, xb;
    logic [WID-1:0]    hi, lo, o_d, o_q;
    logic [TAGW-1:0]   o_tag_q;
    logic              ovf_d, ovf_q, done_q;

    // Extending both operands to 2*WID lets one unsigned multiplier serve every op:
    // the low 2*WID bits of the product are identical for signed and unsigned forms.
    always_comb begin
        xa    = (op == 3'd0 || op == 3'd2 || op == 3'd4) ? {{WID{a[WID-1]}}, a} : {{WID{1'b0}}, a};
        xb    = (op == 3'd0 || op == 3'd2) ? {{WID{b[WID-1]}}, b} : {{WID{1'b0}}, b};
        v_d   = {v_q[STAGES-2:0], issue};
        hi    = p_q[STAGES-1][PW-1:WID];
        lo    = p_q[STAGES-1][WID-1:0];
        o_d   = (op_q[STAGES-1] <= 3'd1) ? lo : (op_q[STAGES-1] <= 3'd4) ? hi : '0;
        ovf_d = (op_q[STAGES-1] == 3'd0) ? (hi != {WID{lo[WID-1]}}) :
                (op_q[STAGES-1] == 3'd1) ? |hi : 1'b0;
    end

    // Data path is left unreset; only the valid chain qualifies it.
    always_ff @(posedge clk) begin
        p_q[0]   <= xa * xb;
        op_q[0]  <= op;
        tag_q[0] <= tag;
        for (int i = 1; i < STAGES; i++) begin
            p_q[i]   <= p_q[i-1];
            op_q[i]  <= op_q[i-1];
            tag_q[i] <= tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush)
            v_q <= '0;
        else
            v_q <= v_d;
    end

    // Flush suppresses the op leaving the last stage as well, so the output
    // register is neither updated nor marked done on a flush edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q     <= '0;
            o_tag_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (flush) begin
            done_q <= 1'b0;
        end else begin
            done_q <= v_q[STAGES-1];
            if (v_q[STAGES-1]) begin
                o_q     <= o_d;
                o_tag_q <= tag_q[STAGES-1];
                ovf_q   <= ovf_d;
            end
        end
    end

    assign o        = o_q;
    assign o_tag    = o_tag_q;
    assign ovf      = ovf_q;
    assign mul_done = done_q;
endmodule

// File: tb/tb_qupls4_imul_pipe.sv
// tb_qupls4_imul_pipe: randomized and directed check of qupls4_imul_pipe against an arithmetic model
module tb_qupls4_imul_pipe;
    localparam int WID = 64;
    localparam int S   = 3;
    localparam int TW  = 8;

    logic           clk = 1'b0;
    logic           rst, issue, flush;
    logic [2:0]     op;
    logic [WID-1:0] a, b;
    logic [TW-1:0]  tag;
    logic [WID-1:0] o;
    logic [TW-1:0]  o_tag;
    logic           ovf, mul_done;

    always #5 clk = ~clk;

    qupls4_imul_pipe #(.WID(WID), .STAGES(S), .TAGW(TW), .LANE(0)) dut (
        .clk(clk), .rst(rst), .issue(issue), .op(op), .a(a), .b(b), .tag(tag),
        .flush(flush), .o(o), .o_tag(o_tag), .ovf(ovf), .mul_done(mul_done)
    );

    typedef struct {
        int            due;
        logic [63:0]   res;
        logic [TW-1:0] t;
        logic          v;
    } ent_t;

    ent_t          pend[$];
    int            edge_n = 0;
    int            errors = 0;
    int            checks = 0;
    logic [63:0]   e_o;
    logic [TW-1:0] e_t;
    logic          e_v, e_d;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", nm, edge_n, got, exp);
        end
    endtask

    // Result and overflow straight from the arithmetic value of the product.
    function automatic logic [64:0] ref_mul(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y);
        logic signed [129:0] sx, sy, ux, uy, p, lim;
        sx  = $signed(x);
        sy  = $signed(y);
        ux  = {66'b0, x};
        uy  = {66'b0, y};
        lim = 130'sd1 <<< 63;
        case (f)
            3'd0: begin p = sx * sy; return {(p >= lim) || (p < -lim), p[63:0]}; end
            3'd1: begin p = ux * uy; return {p >= (lim <<< 1), p[63:0]}; end
            3'd2: begin p = sx * sy; return {1'b0, p[127:64]}; end
            3'd3: begin p = ux * uy; return {1'b0, p[127:64]}; end
            3'd4: begin p = sx * uy; return {1'b0, p[127:64]}; end
            default: return 65'd0;
        endcase
    endfunction

    task automatic step(input logic i_rst, input logic i_iss, input logic i_fl, input logic [2:0] i_op,
                        input logic [63:0] i_a, input logic [63:0] i_b, input logic [TW-1:0] i_t);
        logic [64:0] r;
        rst = i_rst; issue = i_iss; flush = i_fl; op = i_op; a = i_a; b = i_b; tag = i_t;
        @(posedge clk);
        edge_n++;
        if (i_rst) begin
            pend.delete();
            e_o = '0; e_t = '0; e_v = 1'b0; e_d = 1'b0;
        end else if (i_fl) begin
            pend.delete();
            e_d = 1'b0;
        end else begin
            e_d = 1'b0;
            if (pend.size() > 0 && pend[0].due == edge_n) begin
                e_o = pend[0].res; e_t = pend[0].t; e_v = pend[0].v; e_d = 1'b1;
                void'(pend.pop_front());
            end
            if (i_iss) begin
                r = ref_mul(i_op, i_a, i_b);
                pend.push_back('{edge_n + S, r[63:0], i_t, r[64]});
            end
        end
        #1;
        chk("mul_done", {63'b0, mul_done}, {63'b0, e_d});
        chk("o", o, e_o);
        chk("o_tag", {56'b0, o_tag}, {56'b0, e_t});
        chk("ovf", {63'b0, ovf}, {63'b0, e_v});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 64'd0, 64'd0, 8'd0);
    endtask

    task automatic iss(input logic [2:0] f, input logic [63:0] x, input logic [63:0] y, input logic [TW-1:0] t);
        step(0, 1, 0, f, x, y, t);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 4))
            0: return {$urandom, $urandom};
            1: return 64'($signed($urandom_range(0, 200)) - 100);
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'd1 << $urandom_range(0, 63);
            default: return {32'd0, $urandom};
        endcase
    endfunction

    initial begin
        step(1, 0, 0, 3'd0, 64'd0, 64'd0, 8'd0);
        step(1, 0, 0, 3'd0, 64'd0, 64'd0, 8'd0);
        idle(2);
        iss(3'd0, -64'sd3, 64'd5, 8'h11);
        idle(4);
        iss(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8'h21);
        iss(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8'h22);
        iss(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 8'h23);
        idle(4);
        iss(3'd1, 64'h1_0000_0000, 64'h1_0000_0000, 8'h31);
        iss(3'd0, 64'h4000_0000_0000_0000, 64'd2, 8'h32);
        iss(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h33);
        iss(3'd6, 64'd7, 64'd9, 8'h34);
        idle(4);
        iss(3'd0, 64'd12, 64'd13, 8'd1);
        iss(3'd1, 64'hDEAD_BEEF, 64'h1234_5678, 8'd2);
        iss(3'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 8'd3);
        idle(4);
        iss(3'd0, 64'd100, 64'd3, 8'd5);
        step(0, 1, 1, 3'd0, 64'd200, 64'd3, 8'd6);
        iss(3'd0, 64'd300, 64'd3, 8'd7);
        idle(5);
        iss(3'd0, 64'd4, 64'd4, 8'h41);
        iss(3'd1, 64'd5, 64'd5, 8'h42);
        step(1, 0, 0, 3'd0, 64'd0, 64'd0, 8'd0);
        idle(4);
        iss(3'd3, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 8'h43);
        idle(4);
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0,
                 3'($urandom_range(0, 7)), pick(), pick(), 8'($urandom));
        end
        idle(S + 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
